// File: rtl/xs3_to_bcd_deframer.sv
// xs3_to_bcd_deframer
// Receives excess-3 digit codes, most significant digit first, over valid/ready.
// Each code is decoded to BCD (illegal codes become 0 and are flagged).
// NDIGITS digits are packed into one word, which is presented on valid/ready.
// Optional macro XS3_BIN_EN adds out_bin, the running binary value of the word.
module xs3_to_bcd_deframer #(
  parameter int unsigned NDIGITS = 4,
  parameter int unsigned BIN_W   = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_xs3,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NDIGITS-1:0]   out_bcd,
  output logic                   out_err,
  output logic [NDIGITS-1:0]     out_err_mask
`ifdef XS3_BIN_EN
  ,
  output logic [BIN_W-1:0]       out_bin
`endif
);

  localparam int unsigned W     = 4 * NDIGITS;
  localparam int unsigned CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIGITS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    OUT     = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       bcd_q, bcd_d;
  logic [NDIGITS-1:0] mask_q, mask_d;
  logic               err_q, err_d;
`ifdef XS3_BIN_EN
  logic [BIN_W-1:0]   bin_q, bin_d;
`endif

  logic       accept;
  logic       dig_err;
  logic [3:0] dig;

  // State and data registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      bcd_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
`ifdef XS3_BIN_EN
      bin_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
`ifdef XS3_BIN_EN
      bin_q   <= bin_d;
`endif
    end
  end

  // Next-state: decode the incoming code, shift it into the word, advance the FSM
  always_comb begin
    dig_err = (in_xs3 < 4'd3) || (in_xs3 > 4'd12);
    dig     = dig_err ? 4'd0 : (in_xs3 - 4'd3);
    accept  = in_valid && (state_q == COLLECT);

    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    mask_d  = mask_q;
    err_d   = err_q;
`ifdef XS3_BIN_EN
    bin_d   = bin_q;
`endif

    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          bcd_d  = (bcd_q << 4) | W'(dig);
          mask_d = (mask_q << 1) | NDIGITS'(dig_err);
          // Error flag registered alongside the mask so it is stable in OUT
          err_d  = |mask_d;
`ifdef XS3_BIN_EN
          bin_d  = (cnt_q == '0) ? BIN_W'(dig)
                                 : (bin_q * BIN_W'(10) + BIN_W'(dig));
`endif
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = OUT;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      OUT: begin
        if (out_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // Outputs: handshake flags from state, data straight from registers
  always_comb begin
    in_ready     = (state_q == COLLECT);
    out_valid    = (state_q == OUT);
    out_bcd      = bcd_q;
    out_err_mask = mask_q;
    out_err      = err_q;
`ifdef XS3_BIN_EN
    out_bin      = bin_q;
`endif
  end

endmodule

// File: tb/tb_xs3_to_bcd_deframer.sv
// Directed self-checking bench for xs3_to_bcd_deframer (NDIGITS=4, BIN_W=14).
// out_bin checks are compiled in only when XS3_BIN_EN is defined.
module tb_xs3_to_bcd_deframer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_xs3;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bcd;
  logic        out_err;
  logic [3:0]  out_err_mask;
`ifdef XS3_BIN_EN
  logic [13:0] out_bin;
`endif

  int total = 0;
  int bad   = 0;

  xs3_to_bcd_deframer #(
    .NDIGITS (4),
    .BIN_W   (14)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_xs3       (in_xs3),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bcd      (out_bcd),
    .out_err      (out_err),
    .out_err_mask (out_err_mask)
`ifdef XS3_BIN_EN
    ,
    .out_bin      (out_bin)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one digit for exactly one clock edge, then sample 1 time unit later
  task automatic send(input logic [3:0] d);
    in_valid = 1'b1;
    in_xs3   = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_xs3   = 4'h0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_bcd"},       32'(out_bcd),   32'h0);
    check({tag, "_mask"},      32'(out_err_mask), 32'h0);
    check({tag, "_err"},       32'(out_err),   32'd0);
`ifdef XS3_BIN_EN
    check({tag, "_bin"},       32'(out_bin),   32'd0);
`endif
  endtask

  logic       tv_valid [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [3:0] tv_data  [7] = '{4'hC, 4'h7, 4'h1, 4'hB, 4'hF, 4'h5, 4'h6};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_xs3    = 4'h0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    // Word 1: 4,8,A,C -> 1579, no errors
    send(4'h4);
    send(4'h8);
    send(4'hA);
    check("w1_not_yet_valid", 32'(out_valid), 32'd0);
    send(4'hC);
    check("w1_valid", 32'(out_valid), 32'd1);
    check("w1_in_ready", 32'(in_ready), 32'd0);
    check("w1_bcd", 32'(out_bcd), 32'h1579);
    check("w1_err", 32'(out_err), 32'd0);
    check("w1_mask", 32'(out_err_mask), 32'h0);
`ifdef XS3_BIN_EN
    check("w1_bin", 32'(out_bin), 32'd1579);
`endif
    step;
    check("w1_back_collect", 32'(in_ready), 32'd1);
    check("w1_valid_drop", 32'(out_valid), 32'd0);

    // Word 2: 4,2,3,F -> 1000 with digits 2 and 0 illegal
    send(4'h4);
    send(4'h2);
    send(4'h3);
    send(4'hF);
    check("w2_valid", 32'(out_valid), 32'd1);
    check("w2_bcd", 32'(out_bcd), 32'h1000);
    check("w2_mask", 32'(out_err_mask), 32'b0101);
    check("w2_err", 32'(out_err), 32'd1);
`ifdef XS3_BIN_EN
    check("w2_bin", 32'(out_bin), 32'd1000);
`endif
    step;

    // Word 3: all 0x3 -> 0000, held for 5 cycles with out_ready low
    out_ready = 1'b0;
    send(4'h3);
    send(4'h3);
    send(4'h3);
    send(4'h3);
    in_valid = 1'b1;
    in_xs3   = 4'h9;
    for (int i = 0; i < 5; i++) begin
      check("w3_hold_valid", 32'(out_valid), 32'd1);
      check("w3_hold_ready", 32'(in_ready), 32'd0);
      check("w3_hold_bcd", 32'(out_bcd), 32'h0000);
      check("w3_hold_err", 32'(out_err), 32'd0);
      step;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step;
    check("w3_release_valid", 32'(out_valid), 32'd0);
    check("w3_release_ready", 32'(in_ready), 32'd1);
    check("w3_data_kept", 32'(out_bcd), 32'h0000);

    // Word 4: gapped input C,-,-,B,-,5,6 -> 9823
    for (int i = 0; i < 7; i++) begin
      in_valid = tv_valid[i];
      in_xs3   = tv_data[i];
      step;
      if (i == 5) check("w4_not_yet_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    check("w4_valid", 32'(out_valid), 32'd1);
    check("w4_bcd", 32'(out_bcd), 32'h9823);
    check("w4_mask", 32'(out_err_mask), 32'h0);
`ifdef XS3_BIN_EN
    check("w4_bin", 32'(out_bin), 32'd9823);
`endif
    step;

    // Word 5: all illegal codes at both range edges -> 0000, mask 1111
    send(4'hD);
    send(4'h0);
    send(4'h1);
    send(4'hE);
    check("w5_valid", 32'(out_valid), 32'd1);
    check("w5_bcd", 32'(out_bcd), 32'h0000);
    check("w5_mask", 32'(out_err_mask), 32'hF);
    check("w5_err", 32'(out_err), 32'd1);
    step;

    // Abort after two digits, then a clean word 5,6,7,8 -> 2345
    send(4'h9);
    send(4'hA);
    rst = 1'b1;
    step;
    check_zero_outputs("midword_rst");
    rst = 1'b0;
    out_ready = 1'b0;
    send(4'h5);
    send(4'h6);
    send(4'h7);
    check("w6_not_yet_valid", 32'(out_valid), 32'd0);
    send(4'h8);
    check("w6_valid", 32'(out_valid), 32'd1);
    check("w6_bcd", 32'(out_bcd), 32'h2345);
    check("w6_mask", 32'(out_err_mask), 32'h0);
`ifdef XS3_BIN_EN
    check("w6_bin", 32'(out_bin), 32'd2345);
`endif

    // Reset while in OUT
    step;
    check("w6_still_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step;
    check_zero_outputs("out_rst");
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xs3_to_bcd_deframer.md
Name: xs3_to_bcd_deframer

Overview:
- Receive end of the team's excess-3 (XS3) digit link; inverse of the BCD-to-XS3 encoder.
- Accepts a stream of 4-bit XS3 codes, most significant digit first, via valid/ready.
- Subtracts 3 from each code, packs NDIGITS decoded BCD digits into one word and presents the word on a valid/ready output.
- Flags codes outside the legal XS3 range 0011..1100.

Parameters:
- NDIGITS, 4, number of BCD digits per output word (>=1).
- BIN_W, 14, width of optional binary output; must hold 10^NDIGITS-1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_xs3 holds a digit
- in_ready  out  1  block can accept a digit
- in_xs3  in  4  excess-3 code
- out_valid  out  1  packed word available
- out_ready  in  1  consumer takes the word
- out_bcd  out  4*NDIGITS  packed BCD; digit i at [4i+3:4i], first-received digit at i=NDIGITS-1
- out_err  out  1  OR of out_err_mask
- out_err_mask  out  NDIGITS  bit i set if digit i's code was illegal
- out_bin  out  BIN_W  binary value of word (only with XS3_BIN_EN)

Behaviour:
- Decode per digit: code c in 0011..1100 gives BCD c-3 (4-bit). Codes 0000, 0001, 0010, 1101, 1110, 1111 are illegal: decoded digit forced to 0000 and err bit set.
- States:
  - COLLECT (reset state): in_ready=1, out_valid=0.
  - OUT: in_ready=0, out_valid=1.
- Accept: in_valid & in_ready on a rising edge.
  - Shift out_bcd left 4 and insert the decoded digit at [3:0].
  - Shift out_err_mask left 1 and insert the error bit.
  - Increment digit counter cnt (0..NDIGITS-1).
- On accepting the digit with cnt==NDIGITS-1:
  - cnt wraps to 0 and state goes to OUT.
  - out_valid rises the cycle after the final handshake (1-cycle latency).
- OUT:
  - out_bcd, out_err_mask, out_err and out_bin held stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready: return to COLLECT next cycle.
  - Output data registers are not cleared on handoff; their contents are don't-care while out_valid=0.
  - No input is accepted in the cycle of the output handshake. Throughput is NDIGITS+1 cycles per word at best.
- in_valid gaps during COLLECT are allowed; cnt and partial data hold.
- in_xs3 is ignored when in_valid=0 or state=OUT.
- Illegal code does not stop collection; the word still completes after NDIGITS digits.
- NDIGITS=1: every accepted digit moves to OUT.
- Reset at any time, including mid-word or in OUT:
  - state=COLLECT, cnt=0, out_valid=0, in_ready=1.
  - out_bcd=0, out_err_mask=0, out_err=0, out_bin=0.
  - Partial word is discarded.
- out_err is registered together with the mask; never glitches during OUT.

Optional Feature:
- Macro XS3_BIN_EN.
- Defined:
  - out_bin port exists.
  - On each accept, bin <= bin*10 + decoded digit, truncated to BIN_W bits (illegal digit contributes 0).
  - bin clears to 0 on accepting the first digit of a word (cnt==0 accept loads the digit alone).
  - out_bin is valid in OUT with the same hold rules as out_bcd.
- Undefined:
  - out_bin port and all multiply/add logic absent.
  - Remaining behaviour identical.

Test Plan:
- Reset, then digits 0x4,0x8,0xA,0xC with out_ready=1 -> out_valid 1 cycle after 4th accept, out_bcd=0x1579, out_err=0, mask=0000, out_bin=0x062B (1579).
- Digits 0x4,0x2,0x3,0xF -> out_bcd=0x1000, out_err_mask=4'b0101, out_err=1, out_bin=1000.
- Word 0x3,0x3,0x3,0x3 with out_ready=0 for 5 cycles -> out_valid stays 1, out_bcd=0x0000 stable, in_ready=0 throughout. Raise out_ready -> COLLECT next cycle, in_ready=1.
- in_valid toggling 1,0,0,1,0,1,1 carrying 0xC,x,x,0xB,x,0x5,0x6 -> out_bcd=0x9823, out_bin=9823.
- Two digits accepted, then rst pulse 1 cycle, then 0x5,0x6,0x7,0x8 -> out_bcd=0x2345, no residue from aborted word.
- Assert rst during OUT -> next cycle out_valid=0, in_ready=1, all outputs 0.
